// File: rtl/alu_seq_shifter_rv32i.sv
// alu_seq_shifter_rv32i: multi-cycle RV32I shifter (SLL/SRL/SRA) with a
// start/done handshake. Each SHIFT cycle moves the operand one position.
// Optional macro ALU_SEQ_SHIFT_STEP4_EN: a SHIFT cycle moves four positions
// while at least four remain, which shortens long shifts. Results are the same
// in both builds.
// The operation-select port is named shift_type because `type` is a reserved
// word in SystemVerilog.
module alu_seq_shifter_rv32i (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in,
  input  logic [31:0] shamt,
  input  logic [1:0]  shift_type,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] data;
  logic [4:0]  cnt;
  logic [1:0]  op;

  logic        big_step;
  logic [31:0] step_data;
  logic [4:0]  step_cnt;

  // Only shamt[4:0] selects the shift amount; the upper bits are ignored.
  logic        shamt_unused;
  assign shamt_unused = ^shamt[31:5];

  // Choose the step size and compute the operand and count after one step.
  always_comb begin
`ifdef ALU_SEQ_SHIFT_STEP4_EN
    big_step = (cnt >= 5'd4);
`else
    big_step = 1'b0;
`endif
    step_data = '0;
    case (op)
      2'b00:   step_data = big_step ? (data << 4) : (data << 1);
      2'b01:   step_data = big_step ? (data >> 4) : (data >> 1);
      2'b10:   step_data = big_step ? 32'($signed(data) >>> 4)
                                    : 32'($signed(data) >>> 1);
      default: step_data = '0;
    endcase
    step_cnt = cnt - (big_step ? 5'd4 : 5'd1);
  end

  // Control FSM, shift datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      op    <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op    <= shift_type;
            // Type 11 returns zero, so it is loaded as a zero-length shift of zero.
            data  <= (shift_type == 2'b11) ? '0 : in;
            cnt   <= (shift_type == 2'b11) ? '0 : shamt[4:0];
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != 5'd0) begin
            data <= step_data;
            cnt  <= step_cnt;
          end else begin
            out   <= data;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_shifter_rv32i.sv
// Directed testbench for alu_seq_shifter_rv32i. It uses a vector table plus
// hand-written sequences for ignored start requests and a reset that arrives
// during an operation. It follows ALU_SEQ_SHIFT_STEP4_EN for the expected cycle counts.
module tb_alu_seq_shifter_rv32i;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] in;
  logic [31:0] shamt;
  logic [1:0]  shift_type;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int unsigned tests = 0;
  int unsigned fails = 0;

  alu_seq_shifter_rv32i dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in         (in),
    .shamt      (shamt),
    .shift_type (shift_type),
    .busy       (busy),
    .done       (done),
    .out        (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] a;
    logic [31:0] s;
    logic [31:0] exp_out;
    int          dc1;   // cycle of done, single-step build
    int          dc4;   // cycle of done, step-4 build
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int pick(input int d1, input int d4);
`ifdef ALU_SEQ_SHIFT_STEP4_EN
    pick = d4;
`else
    pick = d1;
`endif
  endfunction

  // Wait until the DUT is idle, with a bounded cycle budget.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Issue one request and observe the result, the done cycle and the busy window.
  task automatic run_op(input string name, input logic [1:0] t, input logic [31:0] a,
                        input logic [31:0] s, input logic [31:0] exp_out, input int exp_dc);
    int          dc;
    int          busy_err;
    int          done_cnt;
    logic [31:0] res;
    logic [31:0] held;
    wait_idle();
    @(negedge clk);
    start = 1'b1; shift_type = t; in = a; shamt = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble the operands to show that the latched copies are used.
    in = $urandom; shamt = $urandom; shift_type = 2'($urandom);
    dc = -1; busy_err = 0; done_cnt = 0; res = 'x; held = 'x;
    for (int c = 1; c <= exp_dc + 1 && c <= 40; c++) begin
      @(negedge clk);
      if (busy !== (c <= exp_dc)) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (dc < 0) begin
          dc  = c;
          res = out;
        end
      end
      if (c == exp_dc + 1) held = out;
    end
    chk({name, "_out"}, res, exp_out);
    chk({name, "_done_cycle"}, 32'(dc), 32'(exp_dc));
    chk({name, "_busy_window"}, 32'(busy_err), 32'd0);
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, "_out_hold"}, held, exp_out);
  endtask

  initial begin
    int          dc;
    int          dcnt;
    int          exp_dc;
    logic [31:0] res;

    vecs[0]  = '{2'b10, 32'h8000_0000, 32'd4,    32'hF800_0000, 6,  3};
    vecs[1]  = '{2'b00, 32'h0000_0001, 32'd31,   32'h8000_0000, 33, 12};
    vecs[2]  = '{2'b01, 32'hF000_0000, 32'h25,   32'h0780_0000, 7,  4};
    vecs[3]  = '{2'b00, 32'hDEAD_BEEF, 32'd0,    32'hDEAD_BEEF, 2,  2};
    vecs[4]  = '{2'b01, 32'hDEAD_BEEF, 32'd0,    32'hDEAD_BEEF, 2,  2};
    vecs[5]  = '{2'b10, 32'hDEAD_BEEF, 32'd0,    32'hDEAD_BEEF, 2,  2};
    vecs[6]  = '{2'b11, 32'hDEAD_BEEF, 32'd9,    32'h0000_0000, 2,  2};
    vecs[7]  = '{2'b10, 32'h8000_0000, 32'd31,   32'hFFFF_FFFF, 33, 12};
    vecs[8]  = '{2'b10, 32'h7FFF_FFFF, 32'd31,   32'h0000_0000, 33, 12};
    vecs[9]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 33, 12};
    vecs[10] = '{2'b00, 32'h1234_5678, 32'd7,    32'h1A2B_3C00, 9,  6};

    rst_n = 1'b0; start = 1'b0; in = '0; shamt = '0; shift_type = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_out", out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].t, vecs[i].a, vecs[i].s,
             vecs[i].exp_out, pick(vecs[i].dc1, vecs[i].dc4));
    end

    // A start request while busy is ignored. If start is held high, the next
    // request is accepted only after the unit returns to IDLE.
    exp_dc = pick(10, 4);
    wait_idle();
    @(negedge clk);
    start = 1'b1; shift_type = 2'b00; in = 32'h1; shamt = 32'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    dc = -1; res = 'x;
    for (int c = 1; c <= exp_dc + 2; c++) begin
      @(negedge clk);
      if (c == 3) begin
        start = 1'b1; in = 32'hFFFF_FFFF;
      end
      if (done === 1'b1 && dc < 0) begin
        dc = c; res = out;
      end
      if (c == exp_dc + 1) chk("ignore_idle_gap", {31'd0, busy}, 32'd0);
      if (c == exp_dc + 2) chk("ignore_reaccept", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    chk("ignore_out", res, 32'h0000_0100);
    chk("ignore_done_cycle", 32'(dc), 32'(exp_dc));
    dc = -1; res = 'x;
    for (int c = 0; c < 40 && dc < 0; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dc = c; res = out;
      end
    end
    chk("second_req_out", res, 32'hFFFF_FF00);

    // A reset during an operation discards it and no done pulse follows.
    wait_idle();
    @(negedge clk);
    start = 1'b1; shift_type = 2'b10; in = 32'h8000_0000; shamt = 32'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_out", out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("midrst_no_done", 32'(dcnt), 32'd0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    run_op("post_rst_srl", 2'b01, 32'h10, 32'd4, 32'h1, pick(6, 3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
